// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Operands are reduced to magnitudes at capture. One quotient bit is
// produced per CALC cycle, and the signs are reapplied in DONE.
// Results and done are registered, so both become visible in the cycle
// after DONE.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             sign_a;     // dividend sign, already masked by signed_div
    logic             sign_b;     // divisor sign, already masked by signed_div
    logic             div0;
    logic [WIDTH-1:0] bmag;
    logic [WIDTH-1:0] dq;         // dividend shift reg, becomes quotient
    logic [WIDTH-1:0] prem;       // partial remainder

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, diff;
    logic             q_bit;

    // Operand magnitudes and the trial subtraction for one restoring step
    always_comb begin
        a_mag   = (signed_div && a[WIDTH-1]) ? (-a) : a;
        b_mag   = (signed_div && b[WIDTH-1]) ? (-b) : b;
        shifted = {prem, dq[WIDTH-1]};
        diff    = shifted - {1'b0, bmag};
        q_bit   = ~diff[WIDTH];
    end

    assign stall = ((state == IDLE) && start && !cancel) || (state == CALC);
    assign busy  = (state != IDLE);

    // Control FSM and datapath. Cancel overrides every transition and
    // suppresses the DONE writeback.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            div0      <= 1'b0;
            bmag      <= '0;
            dq        <= '0;
            prem      <= '0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            sign_a <= signed_div & a[WIDTH-1];
                            sign_b <= signed_div & b[WIDTH-1];
                            bmag   <= b_mag;
                            // Divide by zero keeps the raw dividend for the remainder
                            dq     <= (b == '0) ? a : a_mag;
                            div0   <= (b == '0);
                            prem   <= '0;
                            cnt    <= '0;
                            state  <= (b == '0) ? DONE : CALC;
                        end
                    end
                    CALC: begin
                        prem <= q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                        dq   <= {dq[WIDTH-2:0], q_bit};
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(WIDTH - 1))
                            state <= DONE;
                    end
                    DONE: begin
                        done <= 1'b1;
                        if (div0) begin
                            quotient  <= '1;
                            remainder <= dq;
                        end else begin
                            quotient  <= (sign_a ^ sign_b) ? (-dq) : dq;
                            remainder <= sign_a ? (-prem) : prem;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
